// File: rtl/pifo_pkg.sv
// Shared types for the push-in/first-out buffer: operating modes, per-slot
// next-state selects, the decoded operation of a cycle and a width helper.
package pifo_pkg;

  typedef enum logic {
    PIFO_MODE_BLOCK = 1'b0,
    PIFO_MODE_EVICT = 1'b1
  } pifo_mode_e;

  // Where a storage slot takes its next value from.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_NEXT = 2'd1,
    SEL_PREV = 2'd2,
    SEL_NEW  = 2'd3
  } slot_sel_e;

  typedef enum logic [2:0] {
    OP_IDLE       = 3'd0,
    OP_PUSH       = 3'd1,
    OP_POP        = 3'd2,
    OP_PUSH_POP   = 3'd3,
    OP_PUSH_EVICT = 3'd4,
    OP_DROP_NEW   = 3'd5,
    OP_CLEAR      = 3'd6
  } pifo_op_e;

  // Width of an occupancy counter that must be able to hold num_elements.
  function automatic int cnt_width(input int num_elements);
    return $clog2(num_elements + 1);
  endfunction

endpackage

// File: rtl/pifo_evict_if.sv
// Push, pop, flush, occupancy and eviction signals of the PIFO, grouped.
// master = classifier/scheduler side, slave = the PIFO itself.
interface pifo_evict_if #(
  parameter int PRIO_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 5
);

  logic                  i__data_in_valid;
  logic [PRIO_WIDTH-1:0] i__data_in_priority;
  logic [DATA_WIDTH-1:0] i__data_in;
  logic                  o__data_in_ready;

  logic                  o__data_out_valid;
  logic [PRIO_WIDTH-1:0] o__data_out_priority;
  logic [DATA_WIDTH-1:0] o__data_out;
  logic                  i__data_out_ready;

  logic                  i__clear_all;
  logic [CNT_WIDTH-1:0]  o__count;

  logic                  o__evict_valid;
  logic [PRIO_WIDTH-1:0] o__evict_priority;
  logic [DATA_WIDTH-1:0] o__evict_data;

  modport master (
    output i__data_in_valid, i__data_in_priority, i__data_in,
    output i__data_out_ready, i__clear_all,
    input  o__data_in_ready, o__data_out_valid, o__data_out_priority, o__data_out,
    input  o__count, o__evict_valid, o__evict_priority, o__evict_data
  );

  modport slave (
    input  i__data_in_valid, i__data_in_priority, i__data_in,
    input  i__data_out_ready, i__clear_all,
    output o__data_in_ready, o__data_out_valid, o__data_out_priority, o__data_out,
    output o__count, o__evict_valid, o__evict_priority, o__evict_data
  );

endinterface

// File: rtl/pifo_slot.sv
// One storage slot of the sorted buffer: a registered 4-way mux choosing
// between holding, shifting from a neighbour, or loading the incoming entry.
module pifo_slot
  import pifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  slot_sel_e        sel,
  input  logic [WIDTH-1:0] next_entry,
  input  logic [WIDTH-1:0] prev_entry,
  input  logic [WIDTH-1:0] new_entry,
  output logic [WIDTH-1:0] entry
);

  logic [WIDTH-1:0] entry_d;

  // NOTE: entry_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    entry_d = entry;
    case (sel)
      SEL_NEXT: entry_d = next_entry;
      SEL_PREV: entry_d = prev_entry;
      SEL_NEW:  entry_d = new_entry;
      default:  entry_d = entry;
    endcase
  end

  // NOTE: slots are storage but are still reset, because slot 0 drives the
  // head outputs directly and those must read zero while in reset.
  // NOTE: state is updated with <= so all slots sample their neighbours'
  // old values on the same edge, which is what makes the shift work.
  always_ff @(posedge clk) begin
    if (!reset) entry <= '0;
    else        entry <= entry_d;
  end

endmodule

// File: rtl/pifo_evict.sv
// Sorted push-in/first-out buffer with simultaneous push and pop, FIFO order
// among equal ranks and, in evict mode, displacement of the worst entry when full.
module pifo_evict
  import pifo_pkg::*;
#(
  parameter int         NUM_ELEMENTS = 16,
  parameter int         MAX_PRIORITY = 256,
  parameter int         DATA_WIDTH   = 8,
  parameter pifo_mode_e MODE         = PIFO_MODE_BLOCK
) (
  input logic         clk,
  input logic         reset,
  pifo_evict_if.slave bus
);

  localparam int PRIO_WIDTH = $clog2(MAX_PRIORITY);
  localparam int CNT_WIDTH  = cnt_width(NUM_ELEMENTS);
  localparam int ENTRY_W    = DATA_WIDTH + PRIO_WIDTH;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PRIO_WIDTH-1:0] prio;
  } entry_t;

  localparam cnt_t FULL_CNT = cnt_t'(NUM_ELEMENTS);

  entry_t    slot_q [NUM_ELEMENTS];
  slot_sel_e sel    [NUM_ELEMENTS];
  entry_t    new_entry;

  cnt_t      count_q, count_d;
  cnt_t      k, land_pos;
  logic      full, empty, in_ready, push, pop;
  pifo_op_e  op;

  logic      evict_valid_q, evict_fire;
  entry_t    evict_q, evict_d;

  assign new_entry.data = bus.i__data_in;
  assign new_entry.prio = bus.i__data_in_priority;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Ready is combinational on the pop request so a full buffer can sustain
  // push+pop every cycle; evict mode never backpressures.
  assign in_ready = reset & ((MODE == PIFO_MODE_EVICT) | ~full | bus.i__data_out_ready);
  assign push     = bus.i__data_in_valid & in_ready;
  assign pop      = ~empty & bus.i__data_out_ready;

  // Insert position: valid slots ranking ahead of or equal to the newcomer,
  // so equal ranks queue behind the entries already present.
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if ((cnt_t'(i) < count_q) && (slot_q[i].prio <= bus.i__data_in_priority))
        k = k + cnt_t'(1);
    end
  end

  // With a simultaneous pop the head leaves, so everything ahead of k moves down.
  assign land_pos = (k == '0) ? '0 : k - cnt_t'(1);

  always_comb begin
    op = OP_IDLE;
    if (bus.i__clear_all)  op = OP_CLEAR;
    else if (push && pop)  op = OP_PUSH_POP;
    else if (push && full) op = (k == FULL_CNT) ? OP_DROP_NEW : OP_PUSH_EVICT;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
  end

  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) sel[i] = SEL_HOLD;
    count_d    = count_q;
    evict_fire = 1'b0;
    evict_d    = evict_q;

    case (op)
      OP_CLEAR: count_d = '0;

      OP_PUSH, OP_PUSH_EVICT: begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
          if (cnt_t'(i) == k)     sel[i] = SEL_NEW;
          else if (cnt_t'(i) > k) sel[i] = SEL_PREV;
        end
        if (op == OP_PUSH) begin
          count_d = count_q + cnt_t'(1);
        end else begin
          evict_fire = 1'b1;
          evict_d    = slot_q[NUM_ELEMENTS-1];
        end
      end

      OP_DROP_NEW: begin
        evict_fire = 1'b1;
        evict_d    = new_entry;
      end

      OP_POP: begin
        for (int i = 0; i < NUM_ELEMENTS; i++) sel[i] = SEL_NEXT;
        count_d = count_q - cnt_t'(1);
      end

      OP_PUSH_POP: begin
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
          if (cnt_t'(i) < land_pos)       sel[i] = SEL_NEXT;
          else if (cnt_t'(i) == land_pos) sel[i] = SEL_NEW;
        end
      end

      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_slot
    entry_t next_e, prev_e;

    if (i == NUM_ELEMENTS - 1) begin : g_top
      assign next_e = '0;
    end else begin : g_mid_up
      assign next_e = slot_q[i+1];
    end

    if (i == 0) begin : g_head
      assign prev_e = '0;
    end else begin : g_mid_dn
      assign prev_e = slot_q[i-1];
    end

    pifo_slot #(.WIDTH(ENTRY_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .sel        (sel[i]),
      .next_entry (next_e),
      .prev_entry (prev_e),
      .new_entry  (new_entry),
      .entry      (slot_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q       <= '0;
      evict_valid_q <= 1'b0;
      evict_q       <= '0;
    end else begin
      count_q       <= count_d;
      evict_valid_q <= evict_fire;
      evict_q       <= evict_d;
    end
  end

  assign bus.o__data_in_ready     = in_ready;
  assign bus.o__data_out_valid    = ~empty;
  assign bus.o__data_out_priority = slot_q[0].prio;
  assign bus.o__data_out          = slot_q[0].data;
  assign bus.o__count             = count_q;
  assign bus.o__evict_valid       = evict_valid_q;
  assign bus.o__evict_priority    = evict_q.prio;
  assign bus.o__evict_data        = evict_q.data;

endmodule

// File: tb/tb_pifo_evict.sv
// Self-checking bench: three PIFOs (block/4, evict/4, evict/5) share one
// stimulus and are each compared every cycle against an unsorted reference set.
module tb_pifo_evict;
  import pifo_pkg::*;

  localparam int ND = 3;
  localparam int PW = 8;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, out_ready, clear;
  logic [PW-1:0] in_prio;
  logic [DW-1:0] in_data;

  pifo_evict_if #(.PRIO_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if_b ();
  pifo_evict_if #(.PRIO_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if_e4 ();
  pifo_evict_if #(.PRIO_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if_e5 ();

  pifo_evict #(.NUM_ELEMENTS(4), .MAX_PRIORITY(256), .DATA_WIDTH(DW), .MODE(PIFO_MODE_BLOCK))
    u_blk (.clk(clk), .reset(reset), .bus(if_b));
  pifo_evict #(.NUM_ELEMENTS(4), .MAX_PRIORITY(256), .DATA_WIDTH(DW), .MODE(PIFO_MODE_EVICT))
    u_ev4 (.clk(clk), .reset(reset), .bus(if_e4));
  pifo_evict #(.NUM_ELEMENTS(5), .MAX_PRIORITY(256), .DATA_WIDTH(DW), .MODE(PIFO_MODE_EVICT))
    u_ev5 (.clk(clk), .reset(reset), .bus(if_e5));

  assign if_b.i__data_in_valid     = in_valid;
  assign if_b.i__data_in_priority  = in_prio;
  assign if_b.i__data_in           = in_data;
  assign if_b.i__data_out_ready    = out_ready;
  assign if_b.i__clear_all         = clear;
  assign if_e4.i__data_in_valid    = in_valid;
  assign if_e4.i__data_in_priority = in_prio;
  assign if_e4.i__data_in          = in_data;
  assign if_e4.i__data_out_ready   = out_ready;
  assign if_e4.i__clear_all        = clear;
  assign if_e5.i__data_in_valid    = in_valid;
  assign if_e5.i__data_in_priority = in_prio;
  assign if_e5.i__data_in          = in_data;
  assign if_e5.i__data_out_ready   = out_ready;
  assign if_e5.i__clear_all        = clear;

  logic          o_rdy [ND], o_val [ND], o_evv [ND];
  logic [PW-1:0] o_prio[ND], o_evp [ND];
  logic [DW-1:0] o_data[ND], o_evd [ND];
  logic [CW-1:0] o_cnt [ND];

  assign o_rdy[0]  = if_b.o__data_in_ready;      assign o_rdy[1]  = if_e4.o__data_in_ready;
  assign o_rdy[2]  = if_e5.o__data_in_ready;
  assign o_val[0]  = if_b.o__data_out_valid;     assign o_val[1]  = if_e4.o__data_out_valid;
  assign o_val[2]  = if_e5.o__data_out_valid;
  assign o_prio[0] = if_b.o__data_out_priority;  assign o_prio[1] = if_e4.o__data_out_priority;
  assign o_prio[2] = if_e5.o__data_out_priority;
  assign o_data[0] = if_b.o__data_out;           assign o_data[1] = if_e4.o__data_out;
  assign o_data[2] = if_e5.o__data_out;
  assign o_cnt[0]  = if_b.o__count;              assign o_cnt[1]  = if_e4.o__count;
  assign o_cnt[2]  = if_e5.o__count;
  assign o_evv[0]  = if_b.o__evict_valid;        assign o_evv[1]  = if_e4.o__evict_valid;
  assign o_evv[2]  = if_e5.o__evict_valid;
  assign o_evp[0]  = if_b.o__evict_priority;     assign o_evp[1]  = if_e4.o__evict_priority;
  assign o_evp[2]  = if_e5.o__evict_priority;
  assign o_evd[0]  = if_b.o__evict_data;         assign o_evd[1]  = if_e4.o__evict_data;
  assign o_evd[2]  = if_e5.o__evict_data;

  // Reference: an unordered set of entries tagged with arrival order; the head
  // is the minimum by (prio, arrival) and the eviction victim the maximum.
  typedef struct {
    int prio;
    int data;
    int seq;
  } ent_t;

  ent_t m [ND][8];
  int   mcnt [ND];
  int   ne   [ND];
  bit   evict_mode [ND];
  bit   exp_evv [ND];
  int   exp_evp [ND];
  int   exp_evd [ND];
  int   seq_no;
  int   checks;
  int   errors;

  function automatic bit ahead(input ent_t a, input ent_t b);
    return (a.prio < b.prio) || (a.prio == b.prio && a.seq < b.seq);
  endfunction

  function automatic int best_idx(input int d);
    int j = 0;
    for (int i = 1; i < mcnt[d]; i++) if (ahead(m[d][i], m[d][j])) j = i;
    return j;
  endfunction

  function automatic int worst_idx(input int d);
    int j = 0;
    for (int i = 1; i < mcnt[d]; i++) if (ahead(m[d][j], m[d][i])) j = i;
    return j;
  endfunction

  function automatic void drop(input int d, input int j);
    m[d][j] = m[d][mcnt[d]-1];
    mcnt[d]--;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check ready before the edge and all
  // registered outputs just after it.
  task automatic step(input string tag, input bit v, input int p, input int dat,
                      input bit ordy, input bit clr, input bit rst_n);
    bit   rdy, push, pop;
    int   j;
    ent_t e;
    in_valid  = v;
    in_prio   = PW'(p);
    in_data   = DW'(dat);
    out_ready = ordy;
    clear     = clr;
    reset     = rst_n;
    #1;
    for (int d = 0; d < ND; d++) begin
      rdy = rst_n && (evict_mode[d] || mcnt[d] < ne[d] || ordy);
      check({tag, ".ready"}, d, 32'(o_rdy[d]), 32'(rdy));
      push = v && rdy;
      pop  = (mcnt[d] > 0) && ordy;
      if (!rst_n) begin
        mcnt[d] = 0; exp_evv[d] = 1'b0; exp_evp[d] = 0; exp_evd[d] = 0;
      end else if (clr) begin
        mcnt[d] = 0; exp_evv[d] = 1'b0;
      end else begin
        exp_evv[d] = 1'b0;
        if (pop) drop(d, best_idx(d));
        if (push) begin
          e.prio = p; e.data = dat; e.seq = seq_no;
          m[d][mcnt[d]] = e;
          mcnt[d]++;
          if (mcnt[d] > ne[d]) begin
            j = worst_idx(d);
            exp_evv[d] = 1'b1;
            exp_evp[d] = m[d][j].prio;
            exp_evd[d] = m[d][j].data;
            drop(d, j);
          end
        end
      end
    end
    seq_no++;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check({tag, ".count"}, d, 32'(o_cnt[d]), 32'(mcnt[d]));
      check({tag, ".out_valid"}, d, 32'(o_val[d]), 32'(mcnt[d] > 0));
      if (mcnt[d] > 0) begin
        j = best_idx(d);
        check({tag, ".head_prio"}, d, 32'(o_prio[d]), 32'(m[d][j].prio));
        check({tag, ".head_data"}, d, 32'(o_data[d]), 32'(m[d][j].data));
      end
      check({tag, ".evict_valid"}, d, 32'(o_evv[d]), 32'(exp_evv[d]));
      if (exp_evv[d] || !rst_n) begin
        check({tag, ".evict_prio"}, d, 32'(o_evp[d]), 32'(exp_evp[d]));
        check({tag, ".evict_data"}, d, 32'(o_evd[d]), 32'(exp_evd[d]));
      end
      if (!rst_n) begin
        check({tag, ".rst_head_prio"}, d, 32'(o_prio[d]), 32'd0);
        check({tag, ".rst_head_data"}, d, 32'(o_data[d]), 32'd0);
      end
    end
  endtask

  task automatic push_op(input string tag, input int p, input int dat);
    step(tag, 1'b1, p, dat, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop_op(input string tag);
    step(tag, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    ne         = '{4, 4, 5};
    evict_mode = '{1'b0, 1'b1, 1'b1};
    for (int d = 0; d < ND; d++) begin
      mcnt[d] = 0; exp_evv[d] = 1'b0; exp_evp[d] = 0; exp_evd[d] = 0;
    end
    seq_no = 0;
    checks = 0;
    errors = 0;

    // Reset state, with requests asserted to show they are ignored.
    step("reset0", 1'b1, 3, 8'h33, 1'b1, 1'b0, 1'b0);
    step("reset1", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Priority order with FIFO among equals: B, D, A, C.
    push_op("ord_pushA", 5, 8'hA1);
    push_op("ord_pushB", 2, 8'hB2);
    push_op("ord_pushC", 9, 8'hC3);
    push_op("ord_pushD", 2, 8'hD4);
    for (int i = 0; i < 4; i++) pop_op("ord_pop");

    // Full buffer: push+pop is accepted; push alone blocks or evicts.
    for (int i = 1; i <= 4; i++) push_op("fill_a", i, 8'h10 + i);
    step("full_pushpop", 1'b1, 0, 8'h20, 1'b1, 1'b0, 1'b1);
    push_op("full_push_nopop", 0, 8'h21);
    step("clear_a", 1'b1, 6, 8'h22, 1'b0, 1'b1, 1'b1);

    // Evict the tail for a better rank; drop the newcomer if it ranks last.
    for (int i = 1; i <= 4; i++) push_op("fill_b", i, 8'h30 + i);
    push_op("evict_tail", 2, 8'h35);
    push_op("evict_new", 7, 8'h36);
    for (int i = 0; i < 5; i++) pop_op("drain_b");

    // Push+pop landing position, from {3,6}.
    step("clear_c", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    push_op("pp_fill3", 3, 8'h43);
    push_op("pp_fill6", 6, 8'h46);
    step("pp_in4", 1'b1, 4, 8'h44, 1'b1, 1'b0, 1'b1);
    step("pp_in1", 1'b1, 1, 8'h41, 1'b1, 1'b0, 1'b1);
    pop_op("pp_drain");
    pop_op("pp_drain");

    // Clear beats a simultaneous push.
    for (int i = 0; i < 3; i++) push_op("clr_fill", 8 + i, 8'h50 + i);
    step("clr_with_push", 1'b1, 1, 8'h5F, 1'b0, 1'b1, 1'b1);
    step("clr_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Reset while an eviction pulse is showing.
    for (int i = 1; i <= 5; i++) push_op("rst_fill", 10 * i, 8'h60 + i);
    push_op("rst_evict", 1, 8'h6F);
    step("rst_mid", 1'b1, 2, 8'h70, 1'b1, 1'b0, 1'b0);
    step("rst_hold", 1'b1, 2, 8'h71, 1'b0, 1'b0, 1'b0);
    push_op("rst_release", 4, 8'h72);

    // Random traffic: narrow priority range for ties, occasional clear/reset.
    for (int n = 0; n < 800; n++) begin
      bit v, ordy, clr, rn;
      v    = ($urandom_range(0, 3) != 0);
      ordy = (n < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      rn   = ($urandom_range(0, 199) != 0);
      step("rand", v, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), ordy, clr, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
